// File: rtl/risc_pkg.sv
// Shared types and field layout for the instruction fetch unit.
// An instruction word is [11:8] opcode, [7] indirect flag, [6:0] address.
package risc_pkg;

   localparam int ADDR_W_DEF  = 7;
   localparam int DATA_W_DEF  = 12;
   localparam int TIMEOUT_DEF = 15;

   localparam int OP_MSB    = 11;
   localparam int OP_LSB    = 8;
   localparam int IFLAG_BIT = 7;
   localparam int ADDR_MSB  = 6;

   typedef logic [3:0] opcode_t;

   typedef enum logic {
      IDLE,
      REQ
   } fetch_state_t;

   function automatic opcode_t get_opcode(input logic [DATA_W_DEF-1:0] word);
      return word[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-memory fetch bus: level req/ack handshake with a registered address.
// Memory holds mem_ack and mem_rdata until mem_req drops.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 12
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: increments with natural wrap, or loads a jump target.
// The enable already includes the global freeze, so callers gate it.
module pc_reg #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              en_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (en_i) begin
         pc_d = load_i ? load_val_i : pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC/IR holder that fetches words over a req/ack bus
// with an abort timeout, and exposes decoded IR fields to the Controller.
module instr_fetch_unit
   import risc_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                Ena,
   input  logic                IR_EN,
   input  logic                PC_EN,
   input  logic                PC_LOAD,
   instr_fetch_unit_if.master  mem,
   output opcode_t             OPCODE,
   output logic                I_Flag,
   output logic [ADDR_W-1:0]   InstADDR,
   output logic [ADDR_W-1:0]   PC,
   output logic                fetch_busy,
   output logic                ir_valid,
   output logic                fetch_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   fetch_state_t      state_q;
   logic [DATA_W-1:0] ir_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_req_q;
   logic              busy_q;
   logic              ir_valid_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;

   // Ena is active-low run; a frozen unit must not move the PC either.
   pc_reg #(
      .ADDR_W(ADDR_W)
   ) u_pc_reg (
      .clk        (CLK),
      .srst       (RST),
      .en_i       (PC_EN & ~Ena),
      .load_i     (PC_LOAD),
      .load_val_i (InstADDR),
      .pc_o       (PC)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         ir_q       <= '0;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         ir_valid_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else if (!Ena) begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (IR_EN) begin
                  state_q    <= REQ;
                  mem_addr_q <= PC;
                  mem_req_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
               end
            end
            REQ: begin
               // An ack arriving on the last allowed cycle still completes the fetch.
               if (mem.mem_ack) begin
                  state_q    <= IDLE;
                  ir_q       <= mem.mem_rdata;
                  ir_valid_q <= 1'b1;
                  mem_req_q  <= 1'b0;
                  busy_q     <= 1'b0;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q    <= IDLE;
                  mem_req_q  <= 1'b0;
                  busy_q     <= 1'b0;
                  ir_valid_q <= 1'b0;
                  err_q      <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;

   assign OPCODE     = get_opcode(ir_q);
   assign I_Flag     = ir_q[IFLAG_BIT];
   assign InstADDR   = ir_q[ADDR_MSB:0];
   assign fetch_busy = busy_q;
   assign ir_valid   = ir_valid_q;
   assign fetch_err  = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a transaction-level model tracks the
// expected PC/IR/fetch status and is compared against the DUT every cycle.
module tb_instr_fetch_unit;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic       ir_en = 1'b0;
   logic       pc_en = 1'b0;
   logic       pc_load = 1'b0;
   logic [3:0] opcode;
   logic       i_flag;
   logic [6:0] inst_addr;
   logic [6:0] pc;
   logic       fetch_busy;
   logic       ir_valid;
   logic       fetch_err;

   int unsigned total  = 0;
   int unsigned passed = 0;
   bit          cmp_en = 1'b0;

   instr_fetch_unit_if #(.ADDR_W(7), .DATA_W(12)) mem_bus ();

   instr_fetch_unit #(.ADDR_W(7), .DATA_W(12), .TIMEOUT(TIMEOUT)) dut (
      .CLK        (clk),
      .RST        (rst),
      .Ena        (ena),
      .IR_EN      (ir_en),
      .PC_EN      (pc_en),
      .PC_LOAD    (pc_load),
      .mem        (mem_bus),
      .OPCODE     (opcode),
      .I_Flag     (i_flag),
      .InstADDR   (inst_addr),
      .PC         (pc),
      .fetch_busy (fetch_busy),
      .ir_valid   (ir_valid),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
   endtask

   // Model state: what the fetch unit should be holding, in transaction terms.
   int   m_pc;
   int   m_ir;
   bit   m_valid;
   bit   m_pending;
   int   m_addr;
   int   m_waited;
   bit   m_err;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 0; m_ir = 0; m_valid = 0; m_pending = 0;
         m_addr = 0; m_waited = 0; m_err = 0;
      end else if (!ena) begin
         int next_pc;
         next_pc = m_pc;
         if (pc_en) next_pc = pc_load ? (m_ir % 128) : (m_pc + 1) % 128;
         m_err = 0;
         if (!m_pending) begin
            if (ir_en) begin
               m_pending = 1; m_addr = m_pc; m_waited = 0;
            end
         end else if (mem_bus.mem_ack) begin
            m_ir = int'(mem_bus.mem_rdata);
            m_valid = 1;
            m_pending = 0;
         end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
               m_pending = 0; m_err = 1; m_valid = 0;
            end
         end
         m_pc = next_pc;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mdl_pc",       32'(pc),                  32'(m_pc));
         chk("mdl_opcode",   32'(opcode),              32'(m_ir / 256));
         chk("mdl_iflag",    32'(i_flag),              32'((m_ir / 128) % 2));
         chk("mdl_instaddr", 32'(inst_addr),           32'(m_ir % 128));
         chk("mdl_mem_req",  32'(mem_bus.mem_req),     32'(m_pending));
         chk("mdl_mem_addr", 32'(mem_bus.mem_addr),    32'(m_addr));
         chk("mdl_busy",     32'(fetch_busy),          32'(m_pending));
         chk("mdl_valid",    32'(ir_valid),            32'(m_valid));
         chk("mdl_err",      32'(fetch_err),           32'(m_err));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic fetch(input logic [11:0] word);
      mem_bus.mem_rdata = word;
      ir_en = 1'b1;
      cyc();
      ir_en = 1'b0;
      mem_bus.mem_ack = 1'b1;
      cyc();
      mem_bus.mem_ack = 1'b0;
      $display("fetch word=%03h -> opcode=%0h iflag=%0b addr=%02h valid=%0b", word, opcode, i_flag, inst_addr, ir_valid);
   endtask

   initial begin
      int req_cnt;
      int err_cnt;
      logic [6:0] pc_hold;

      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;

      // Reset held for two edges.
      cyc(); cyc();
      rst = 1'b0;
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_opcode", 32'(opcode), 32'h0);
      chk("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
      chk("rst_ir_valid", 32'(ir_valid), 32'h0);
      cmp_en = 1'b1;
      $display("reset: pc=%02h opcode=%0h req=%0b valid=%0b", pc, opcode, mem_bus.mem_req, ir_valid);

      // First fetch, ack one cycle after the request appears.
      mem_bus.mem_rdata = 12'h0A5;
      ir_en = 1'b1;
      cyc();
      ir_en = 1'b0;
      chk("f1_mem_req", 32'(mem_bus.mem_req), 32'h1);
      chk("f1_mem_addr", 32'(mem_bus.mem_addr), 32'h0);
      mem_bus.mem_ack = 1'b1;
      cyc();
      mem_bus.mem_ack = 1'b0;
      chk("f1_opcode", 32'(opcode), 32'h0);
      chk("f1_iflag", 32'(i_flag), 32'h1);
      chk("f1_instaddr", 32'(inst_addr), 32'h25);
      chk("f1_valid", 32'(ir_valid), 32'h1);
      chk("f1_req_drop", 32'(mem_bus.mem_req), 32'h0);
      $display("fetch word=0a5 -> opcode=%0h iflag=%0b addr=%02h valid=%0b", opcode, i_flag, inst_addr, ir_valid);

      // Walk the PC up to 7F, then wrap.
      pc_en = 1'b1;
      for (int i = 0; i < 127; i++) cyc();
      chk("pc_7f", 32'(pc), 32'h7F);
      cyc();
      pc_en = 1'b0;
      chk("pc_wrap", 32'(pc), 32'h0);
      $display("pc increment wrap: pc=%02h", pc);

      // Jump to IR address; PC_LOAD alone must do nothing.
      fetch(12'h12A);
      pc_en = 1'b1; pc_load = 1'b1;
      cyc();
      pc_en = 1'b0;
      chk("pc_load", 32'(pc), 32'h2A);
      cyc();
      pc_load = 1'b0;
      chk("pc_load_noen", 32'(pc), 32'h2A);
      $display("pc load: pc=%02h", pc);

      // Fetch and increment on the same edge from PC=5.
      fetch(12'h005);
      pc_en = 1'b1; pc_load = 1'b1;
      cyc();
      pc_en = 1'b0; pc_load = 1'b0;
      chk("pc_5", 32'(pc), 32'h5);
      mem_bus.mem_rdata = 12'h301;
      ir_en = 1'b1; pc_en = 1'b1;
      cyc();
      ir_en = 1'b0; pc_en = 1'b0;
      chk("same_mem_addr", 32'(mem_bus.mem_addr), 32'h5);
      chk("same_pc", 32'(pc), 32'h6);
      mem_bus.mem_ack = 1'b1;
      cyc();
      mem_bus.mem_ack = 1'b0;
      chk("same_opcode", 32'(opcode), 32'h3);
      chk("same_instaddr", 32'(inst_addr), 32'h1);
      $display("fetch+inc: addr=05 pc=%02h opcode=%0h instaddr=%02h", pc, opcode, inst_addr);

      // Timeout, with a stray IR_EN while the request is outstanding.
      ir_en = 1'b1;
      cyc();
      ir_en = 1'b0;
      req_cnt = 0; err_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         if (mem_bus.mem_req) req_cnt++;
         if (fetch_err) err_cnt++;
         ir_en = (i >= 2 && i <= 4);
         cyc();
      end
      ir_en = 1'b0;
      chk("to_req_cycles", 32'(req_cnt), 32'(TIMEOUT));
      chk("to_err_pulses", 32'(err_cnt), 32'h1);
      chk("to_opcode", 32'(opcode), 32'h3);
      chk("to_valid", 32'(ir_valid), 32'h0);
      chk("to_mem_req", 32'(mem_bus.mem_req), 32'h0);
      $display("timeout: req_cycles=%0d err_pulses=%0d valid=%0b", req_cnt, err_cnt, ir_valid);

      // Freeze mid-fetch with ack present.
      mem_bus.mem_rdata = 12'h7C3;
      ir_en = 1'b1;
      cyc();
      ir_en = 1'b0;
      pc_hold = pc;
      ena = 1'b1; mem_bus.mem_ack = 1'b1; pc_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("frz_mem_req", 32'(mem_bus.mem_req), 32'h1);
         chk("frz_opcode", 32'(opcode), 32'h3);
         chk("frz_pc", 32'(pc), 32'(pc_hold));
      end
      ena = 1'b0; pc_en = 1'b0;
      cyc();
      mem_bus.mem_ack = 1'b0;
      chk("frz_opcode_ld", 32'(opcode), 32'h7);
      chk("frz_iflag_ld", 32'(i_flag), 32'h1);
      chk("frz_instaddr_ld", 32'(inst_addr), 32'h43);
      $display("freeze release: opcode=%0h iflag=%0b addr=%02h", opcode, i_flag, inst_addr);

      // Reset in the middle of a fetch.
      mem_bus.mem_rdata = 12'hFFF;
      ir_en = 1'b1;
      cyc();
      ir_en = 1'b0;
      chk("mid_req_up", 32'(mem_bus.mem_req), 32'h1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_mem_req", 32'(mem_bus.mem_req), 32'h0);
      chk("mid_busy", 32'(fetch_busy), 32'h0);
      chk("mid_pc", 32'(pc), 32'h0);
      chk("mid_opcode", 32'(opcode), 32'h0);
      mem_bus.mem_ack = 1'b1;
      cyc(); cyc();
      mem_bus.mem_ack = 1'b0;
      chk("mid_late_ack_op", 32'(opcode), 32'h0);
      chk("mid_late_ack_valid", 32'(ir_valid), 32'h0);
      $display("reset mid-fetch: req=%0b pc=%02h opcode=%0h", mem_bus.mem_req, pc, opcode);

      cyc();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
